// File: rtl/axi_pkg.sv
// axi_pkg
//   Shared constants and state encodings for cpu_axi_bridge and its read slot.
//   - AXI IDs for the inst/data read streams
//   - fixed burst/cache/size attribute values
//   - FSM state encodings:
//     - rd_state_e backs both the inst slot (I_IDLE/I_AR/I_R) and the data
//       read path (D_IDLE/D_AR/D_R)
//     - wr_state_e backs the data write path (D_IDLE/D_AW_W/D_B)
//   - axi_cache(): maps the core's cacheable bit to an AXI cache attribute
package axi_pkg;

  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_WB   = 4'b1111;
  localparam logic [3:0] AXI_CACHE_UC   = 4'b0000;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW_W = 2'd1,
    WR_B    = 2'd2
  } wr_state_e;

  function automatic logic [3:0] axi_cache(input logic cacheable);
    return cacheable ? AXI_CACHE_WB : AXI_CACHE_UC;
  endfunction

endpackage

// File: rtl/axi_rd_slot.sv
// axi_rd_slot
//   Single-outstanding read slot:
//   - latches the request payload on acceptance
//   - requests the shared AR channel until granted
//   - captures the routed R beat
//   - pulses data_ok_o for one cycle, returning to idle in that same cycle
//   Ports:
//     clk, resetn            clock, synchronous active-low reset
//     req_i                  request; accepted when the slot is idle
//     addr_i/size_i/cache_i  request payload
//     idle_o                 slot can accept a request this cycle
//     ar_req_o               slot wants the AR channel
//     ar_grant_i             AR handshake completed for this slot
//     araddr_o/arsize_o/arcache_o  latched AR payload
//     rvalid_i/rdata_i       R beat already routed to this slot
//     data_ok_o/rdata_o      registered completion pulse and read word
module axi_rd_slot
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic              cache_i,
  output logic              idle_o,
  output logic              ar_req_o,
  input  logic              ar_grant_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arsize_o,
  output logic [3:0]        arcache_o,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              data_ok_o,
  output logic [DATA_W-1:0] rdata_o
);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [3:0]        cache_q;
  logic              data_ok_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= RD_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      cache_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (req_i) begin
            state_q <= RD_AR;
            addr_q  <= addr_i;
            size_q  <= size_i;
            cache_q <= axi_cache(cache_i);
          end
        end
        RD_AR: begin
          if (ar_grant_i) state_q <= RD_R;
        end
        RD_R: begin
          // Completion is registered: data_ok rises next cycle while the
          // slot is already idle, so a new request can be taken then.
          if (rvalid_i) begin
            state_q   <= RD_IDLE;
            data_ok_q <= 1'b1;
            rdata_q   <= rdata_i;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign idle_o    = (state_q == RD_IDLE);
  assign ar_req_o  = (state_q == RD_AR);
  assign araddr_o  = addr_q;
  assign arsize_o  = size_q;
  assign arcache_o = cache_q;
  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
//   Bridges the core's SRAM-like instruction and data ports onto one AXI3
//   master. Each side allows a single outstanding transaction.
//   Read IDs: inst = 0, data = 1. Responses are routed by rid[0].
//   Ports:
//     clk, resetn                         clock, synchronous active-low reset
//     inst_req/cache/addr                 fetch request
//     inst_addr_ok/data_ok/rdata          fetch handshakes and word
//     data_req/cache/wr/wstrb/size/addr/wdata   load/store request
//     data_addr_ok/data_ok/rdata          data handshakes and load word
//     ar*/r*/aw*/w*/b*                    AXI3 master channels (single beat)
//   Build option:
//     BRIDGE_RAW_CHECK_EN  when defined, an inst AR is held back while a data
//                          write to the same word is in AW/W or awaiting B.
module cpu_axi_bridge
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction port
  input  logic              inst_req,
  input  logic              inst_cache,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data port
  input  logic              data_req,
  input  logic              data_cache,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [2:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // AR
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arcache,
  output logic              arvalid,
  input  logic              arready,
  // R
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AW
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [3:0]        awcache,
  output logic              awvalid,
  input  logic              awready,
  // W
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // B
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  // Slot-side signals
  logic              i_idle, i_ar_req, i_grant, i_rvalid, i_ok;
  logic [ADDR_W-1:0] i_araddr;
  logic [2:0]        i_arsize;
  logic [3:0]        i_arcache;
  logic [DATA_W-1:0] i_rdata;

  logic              d_rd_idle, d_ar_req, d_grant, d_rvalid, d_rd_ok;
  logic [ADDR_W-1:0] d_araddr;
  logic [2:0]        d_arsize;
  logic [3:0]        d_arcache;
  logic [DATA_W-1:0] d_rdata;

  // Write path state
  wr_state_e         wr_state_q;
  logic              awvalid_q, wvalid_q, wr_ok_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [2:0]        awsize_q;
  logic [3:0]        awcache_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic wr_idle, d_idle, d_rd_acc, d_wr_acc;
  logic aw_done, w_done;

  // Response fields that carry no information for this bridge
  logic unused_resp;
  assign unused_resp = ^{rid[3:1], rresp, rlast, bid, bresp};

  // Acceptance: the data side is idle only when neither its read nor its
  // write path holds a transaction.
  assign wr_idle      = (wr_state_q == WR_IDLE);
  assign d_idle       = d_rd_idle && wr_idle;
  assign inst_addr_ok = inst_req && i_idle;
  assign data_addr_ok = data_req && d_idle;
  assign d_rd_acc     = data_addr_ok && !data_wr;
  assign d_wr_acc     = data_addr_ok && data_wr;

  // R routing by the low ID bit; rready is permanently high
  assign rready   = 1'b1;
  assign bready   = 1'b1;
  assign i_rvalid = rvalid && (rid[0] == AXI_ID_INST[0]);
  assign d_rvalid = rvalid && (rid[0] == AXI_ID_DATA[0]);

  axi_rd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_slot (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (inst_req),
    .addr_i     (inst_addr),
    .size_i     (AXI_SIZE_WORD),
    .cache_i    (inst_cache),
    .idle_o     (i_idle),
    .ar_req_o   (i_ar_req),
    .ar_grant_i (i_grant),
    .araddr_o   (i_araddr),
    .arsize_o   (i_arsize),
    .arcache_o  (i_arcache),
    .rvalid_i   (i_rvalid),
    .rdata_i    (rdata),
    .data_ok_o  (i_ok),
    .rdata_o    (i_rdata)
  );

  axi_rd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_slot (
    .clk        (clk),
    .resetn     (resetn),
    .req_i      (d_rd_acc),
    .addr_i     (data_addr),
    .size_i     (data_size),
    .cache_i    (data_cache),
    .idle_o     (d_rd_idle),
    .ar_req_o   (d_ar_req),
    .ar_grant_i (d_grant),
    .araddr_o   (d_araddr),
    .arsize_o   (d_arsize),
    .arcache_o  (d_arcache),
    .rvalid_i   (d_rvalid),
    .rdata_i    (rdata),
    .data_ok_o  (d_rd_ok),
    .rdata_o    (d_rdata)
  );

  // Read-after-write guard for the fetch stream
  logic inst_ar_ok;
`ifdef BRIDGE_RAW_CHECK_EN
  assign inst_ar_ok = !(!wr_idle && (awaddr_q[ADDR_W-1:2] == i_araddr[ADDR_W-1:2]));
`else
  assign inst_ar_ok = 1'b1;
`endif

  // AR arbiter. Data wins a fresh contest, but once arvalid is shown for a
  // slot that owner is locked until arready so the payload never changes
  // under a pending valid.
  logic ar_lock_q, ar_lock_data_q;
  logic ar_sel_data, arvalid_int;

  always_comb begin
    ar_sel_data = 1'b0;
    arvalid_int = 1'b0;
    if (ar_lock_q) begin
      ar_sel_data = ar_lock_data_q;
      arvalid_int = 1'b1;
    end else if (d_ar_req) begin
      ar_sel_data = 1'b1;
      arvalid_int = 1'b1;
    end else if (i_ar_req && inst_ar_ok) begin
      arvalid_int = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_lock_q      <= 1'b0;
      ar_lock_data_q <= 1'b0;
    end else begin
      ar_lock_q      <= arvalid_int && !arready;
      ar_lock_data_q <= ar_sel_data;
    end
  end

  assign i_grant = arvalid_int && arready && !ar_sel_data;
  assign d_grant = arvalid_int && arready && ar_sel_data;

  assign arvalid = arvalid_int;
  assign arid    = ar_sel_data ? AXI_ID_DATA : AXI_ID_INST;
  assign araddr  = ar_sel_data ? d_araddr    : i_araddr;
  assign arsize  = ar_sel_data ? d_arsize    : i_arsize;
  assign arcache = ar_sel_data ? d_arcache   : i_arcache;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;

  // Write path: AW and W launch together, each drops on its own handshake;
  // the B wait begins once both have been taken, in either order.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= WR_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wr_ok_q    <= 1'b0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      awcache_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_ok_q <= 1'b0;
      case (wr_state_q)
        WR_IDLE: begin
          if (d_wr_acc) begin
            wr_state_q <= WR_AW_W;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            awaddr_q   <= data_addr;
            awsize_q   <= data_size;
            awcache_q  <= axi_cache(data_cache);
            wdata_q    <= data_wdata;
            wstrb_q    <= data_wstrb;
          end
        end
        WR_AW_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) wr_state_q <= WR_B;
        end
        WR_B: begin
          if (bvalid) begin
            wr_state_q <= WR_IDLE;
            wr_ok_q    <= 1'b1;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  assign awid    = AXI_ID_DATA;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = AXI_BURST_INCR;
  assign awcache = awcache_q;
  assign awvalid = awvalid_q;

  assign wid    = AXI_ID_DATA;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;

  // Completions to the core
  assign inst_data_ok = i_ok;
  assign inst_rdata   = i_rdata;
  assign data_data_ok = d_rd_ok || wr_ok_q;
  assign data_rdata   = d_rdata;

endmodule
